// File: rtl/regfile_pkg.sv
// Shared definitions for the multi-port register file: default geometry,
// clear-sequencer states and the hardwired zero register index.
package regfile_pkg;

  localparam int unsigned XLEN_DEFAULT  = 64;
  localparam int unsigned NREGS_DEFAULT = 32;
  localparam int unsigned ZERO_REG      = 0;

  typedef enum logic {
    CLEAR,
    RUN
  } state_t;

endpackage

// File: rtl/regfile_rd_bypass.sv
// One read port: index-0 forcing, gating while clearing, and optional
// write-to-read forwarding with the highest-numbered write port winning.
module regfile_rd_bypass
  import regfile_pkg::*;
#(
  parameter int unsigned XLEN   = XLEN_DEFAULT,
  parameter int unsigned AW     = 5,
  parameter int unsigned NUM_WR = 2,
  parameter int unsigned BYPASS = 1
) (
  input  logic                   run,
  input  logic [AW-1:0]          rs,
  input  logic [NUM_WR*AW-1:0]   wr_rd,
  input  logic [NUM_WR*XLEN-1:0] wr_wdata,
  input  logic [NUM_WR-1:0]      wr_wen,
  input  logic [XLEN-1:0]        entry,
  output logic [XLEN-1:0]        rdata
);

  always_comb begin
    rdata = '0;
    if (run && (rs != AW'(ZERO_REG))) begin
      rdata = entry;
      if (BYPASS != 0) begin
        // Ascending scan so the highest-numbered matching port overrides.
        for (int unsigned k = 0; k < NUM_WR; k++) begin
          if (wr_wen[k] && (wr_rd[k*AW +: AW] == rs)) begin
            rdata = wr_wdata[k*XLEN +: XLEN];
          end
        end
      end
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port integer register file with post-reset clear sequencer,
// configurable write-to-read bypass and deterministic write priority.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int unsigned XLEN   = XLEN_DEFAULT,
  parameter int unsigned NREGS  = NREGS_DEFAULT,
  localparam int unsigned AW    = $clog2(NREGS),
  parameter int unsigned NUM_RD = 2,
  parameter int unsigned NUM_WR = 2,
  parameter int unsigned BYPASS = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_WR*AW-1:0]   write_back_i_rd,
  input  logic [NUM_WR*XLEN-1:0] write_back_i_reg_wdata,
  input  logic [NUM_WR-1:0]      write_back_i_reg_wen,
  input  logic [NUM_RD*AW-1:0]   decode_i_rs,
  output logic [NUM_RD*XLEN-1:0] regfile_o_reg_rdata,
  output logic                   regfile_o_ready,
  output logic                   regfile_o_wr_conflict
);

  state_t          state, state_next;
  logic [AW-1:0]   count, count_next;
  logic            ready_next;
  logic            conflict_next;
  logic            run;
  logic [XLEN-1:0] mem [NREGS];

  assign run = (state == RUN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state                 <= CLEAR;
      count                 <= AW'(1);
      regfile_o_ready       <= 1'b0;
      regfile_o_wr_conflict <= 1'b0;
    end else begin
      state                 <= state_next;
      count                 <= count_next;
      regfile_o_ready       <= ready_next;
      regfile_o_wr_conflict <= conflict_next;
    end
  end

  always_comb begin
    state_next = state;
    count_next = count;
    case (state)
      CLEAR: begin
        if (count == AW'(NREGS - 1)) begin
          state_next = RUN;
        end else begin
          count_next = count + AW'(1);
        end
      end
      RUN: state_next = RUN;
      default: state_next = CLEAR;
    endcase
    ready_next = (state_next == RUN);
  end

  always_comb begin
    conflict_next = 1'b0;
    for (int unsigned i = 0; i < NUM_WR; i++) begin
      for (int unsigned j = i + 1; j < NUM_WR; j++) begin
        if (run && write_back_i_reg_wen[i] && write_back_i_reg_wen[j] &&
            (write_back_i_rd[i*AW +: AW] == write_back_i_rd[j*AW +: AW]) &&
            (write_back_i_rd[i*AW +: AW] != AW'(ZERO_REG))) begin
          conflict_next = 1'b1;
        end
      end
    end
  end

  // Storage has no reset; the clear sequencer zeroes entries 1..NREGS-1
  // instead. Entry 0 is never written and is masked on every read.
  always_ff @(posedge clk) begin
    if (!run) begin
      mem[count] <= '0;
    end else begin
      for (int unsigned k = 0; k < NUM_WR; k++) begin
        if (write_back_i_reg_wen[k] &&
            (write_back_i_rd[k*AW +: AW] != AW'(ZERO_REG))) begin
          mem[write_back_i_rd[k*AW +: AW]] <= write_back_i_reg_wdata[k*XLEN +: XLEN];
        end
      end
    end
  end

  for (genvar r = 0; r < NUM_RD; r++) begin : g_rd
    regfile_rd_bypass #(
      .XLEN   (XLEN),
      .AW     (AW),
      .NUM_WR (NUM_WR),
      .BYPASS (BYPASS)
    ) u_rd (
      .run      (run),
      .rs       (decode_i_rs[r*AW +: AW]),
      .wr_rd    (write_back_i_rd),
      .wr_wdata (write_back_i_reg_wdata),
      .wr_wen   (write_back_i_reg_wen),
      .entry    (mem[decode_i_rs[r*AW +: AW]]),
      .rdata    (regfile_o_reg_rdata[r*XLEN +: XLEN])
    );
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard bench for regfile_mp: a bypass and a non-bypass instance share
// stimulus; expected outputs are queued when driven and checked at negedge.
module tb_regfile_mp;

  localparam int unsigned XLEN = 64;
  localparam int unsigned AW   = 5;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [2*AW-1:0]  wr_rd;
  logic [2*XLEN-1:0] wr_wdata;
  logic [1:0]       wr_wen;
  logic [2*AW-1:0]  rs;
  logic [2*XLEN-1:0] rdata_bp, rdata_nb;
  logic             ready_bp, ready_nb, conflict_bp, conflict_nb;

  int tests  = 0;
  int failed = 0;

  typedef struct {
    int          sel;
    logic [63:0] exp;
    string       tag;
  } exp_t;

  exp_t sbq[$];

  always #5 clk = ~clk;

  regfile_mp #(.XLEN(64), .NREGS(32), .NUM_RD(2), .NUM_WR(2), .BYPASS(1)) dut (
    .clk                    (clk),
    .rst_n                  (rst_n),
    .write_back_i_rd        (wr_rd),
    .write_back_i_reg_wdata (wr_wdata),
    .write_back_i_reg_wen   (wr_wen),
    .decode_i_rs            (rs),
    .regfile_o_reg_rdata    (rdata_bp),
    .regfile_o_ready        (ready_bp),
    .regfile_o_wr_conflict  (conflict_bp)
  );

  regfile_mp #(.XLEN(64), .NREGS(32), .NUM_RD(2), .NUM_WR(2), .BYPASS(0)) dut_nb (
    .clk                    (clk),
    .rst_n                  (rst_n),
    .write_back_i_rd        (wr_rd),
    .write_back_i_reg_wdata (wr_wdata),
    .write_back_i_reg_wen   (wr_wen),
    .decode_i_rs            (rs),
    .regfile_o_reg_rdata    (rdata_nb),
    .regfile_o_ready        (ready_nb),
    .regfile_o_wr_conflict  (conflict_nb)
  );

  // sel: 0/1 bypass rdata port, 2/3 non-bypass rdata port,
  //      4 ready_bp, 5 conflict_bp, 6 ready_nb, 7 conflict_nb
  function automatic logic [63:0] observe(int sel);
    case (sel)
      0: return rdata_bp[63:0];
      1: return rdata_bp[127:64];
      2: return rdata_nb[63:0];
      3: return rdata_nb[127:64];
      4: return {63'b0, ready_bp};
      5: return {63'b0, conflict_bp};
      6: return {63'b0, ready_nb};
      7: return {63'b0, conflict_nb};
      default: return '1;
    endcase
  endfunction

  task automatic push(int sel, logic [63:0] v, string tag);
    exp_t e;
    e.sel = sel; e.exp = v; e.tag = tag;
    sbq.push_back(e);
  endtask

  task automatic drive_wr(int k, int idx, logic [63:0] d);
    wr_rd[k*AW +: AW]       = AW'(idx);
    wr_wdata[k*XLEN +: XLEN] = d;
    wr_wen[k]               = 1'b1;
  endtask

  task automatic set_rs(int p, int idx);
    rs[p*AW +: AW] = AW'(idx);
  endtask

  task automatic idle();
    wr_wen = '0;
  endtask

  task automatic test_reset();
    exp_t e;
    logic [63:0] o;
    int n;
    rst_n = 1'b0;
    idle();
    repeat (3) @(posedge clk);
    @(negedge clk);
    push(4, 0, "rst_ready_bp");
    push(5, 0, "rst_conflict_bp");
    push(6, 0, "rst_ready_nb");
    push(7, 0, "rst_conflict_nb");
    while (sbq.size() > 0) begin
      e = sbq.pop_front(); o = observe(e.sel); tests++;
      if (o !== e.exp) begin failed++; $display("FAIL %s: got %h expected %h", e.tag, o, e.exp); end
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    drive_wr(0, 5, 64'h55);
    set_rs(0, 5);
    set_rs(1, 5);
    @(negedge clk);
    push(1, 0, "clear_read_gated");
    push(4, 0, "clear_ready_low");
    while (sbq.size() > 0) begin
      e = sbq.pop_front(); o = observe(e.sel); tests++;
      if (o !== e.exp) begin failed++; $display("FAIL %s: got %h expected %h", e.tag, o, e.exp); end
    end
    n = 0;
    while (ready_bp !== 1'b1 && n < 40) begin
      @(posedge clk); n++;
      #1;
      if (n >= 30) idle();
      @(negedge clk);
    end
    tests++;
    if (n !== 31) begin failed++; $display("FAIL ready_latency: got %0d cycles expected 31", n); end
    push(6, 1, "ready_nb");
    push(0, 0, "x5_write_ignored_bp");
    push(2, 0, "x5_write_ignored_nb");
    while (sbq.size() > 0) begin
      e = sbq.pop_front(); o = observe(e.sel); tests++;
      if (o !== e.exp) begin failed++; $display("FAIL %s: got %h expected %h", e.tag, o, e.exp); end
    end
  endtask

  task automatic test_bypass();
    exp_t e;
    logic [63:0] o;
    @(posedge clk); #1;
    drive_wr(0, 3, 64'hDEAD_BEEF);
    set_rs(0, 3);
    push(0, 64'hDEAD_BEEF, "bypass_same_cycle");
    push(2, 0, "nobypass_same_cycle");
    @(negedge clk);
    while (sbq.size() > 0) begin
      e = sbq.pop_front(); o = observe(e.sel); tests++;
      if (o !== e.exp) begin failed++; $display("FAIL %s: got %h expected %h", e.tag, o, e.exp); end
    end
    @(posedge clk); #1;
    idle();
    push(0, 64'hDEAD_BEEF, "bypass_next_cycle");
    push(2, 64'hDEAD_BEEF, "nobypass_next_cycle");
    @(negedge clk);
    while (sbq.size() > 0) begin
      e = sbq.pop_front(); o = observe(e.sel); tests++;
      if (o !== e.exp) begin failed++; $display("FAIL %s: got %h expected %h", e.tag, o, e.exp); end
    end
  endtask

  task automatic test_conflict();
    exp_t e;
    logic [63:0] o;
    @(posedge clk); #1;
    drive_wr(0, 7, 64'h1111);
    drive_wr(1, 7, 64'h2222);
    set_rs(0, 7);
    push(0, 64'h2222, "conflict_bypass_priority");
    push(2, 0, "conflict_nb_old");
    push(5, 0, "conflict_not_yet");
    @(negedge clk);
    while (sbq.size() > 0) begin
      e = sbq.pop_front(); o = observe(e.sel); tests++;
      if (o !== e.exp) begin failed++; $display("FAIL %s: got %h expected %h", e.tag, o, e.exp); end
    end
    @(posedge clk); #1;
    idle();
    push(0, 64'h2222, "conflict_stored_bp");
    push(2, 64'h2222, "conflict_stored_nb");
    push(5, 1, "conflict_pulse_bp");
    push(7, 1, "conflict_pulse_nb");
    @(negedge clk);
    while (sbq.size() > 0) begin
      e = sbq.pop_front(); o = observe(e.sel); tests++;
      if (o !== e.exp) begin failed++; $display("FAIL %s: got %h expected %h", e.tag, o, e.exp); end
    end
    @(posedge clk); #1;
    push(5, 0, "conflict_one_cycle");
    @(negedge clk);
    while (sbq.size() > 0) begin
      e = sbq.pop_front(); o = observe(e.sel); tests++;
      if (o !== e.exp) begin failed++; $display("FAIL %s: got %h expected %h", e.tag, o, e.exp); end
    end
  endtask

  task automatic test_zero();
    exp_t e;
    logic [63:0] o;
    @(posedge clk); #1;
    drive_wr(0, 0, 64'hFFFF);
    drive_wr(1, 0, 64'h1234);
    set_rs(0, 0);
    set_rs(1, 0);
    push(0, 0, "x0_bypass_p0");
    push(1, 0, "x0_bypass_p1");
    push(2, 0, "x0_nobypass");
    @(negedge clk);
    while (sbq.size() > 0) begin
      e = sbq.pop_front(); o = observe(e.sel); tests++;
      if (o !== e.exp) begin failed++; $display("FAIL %s: got %h expected %h", e.tag, o, e.exp); end
    end
    @(posedge clk); #1;
    idle();
    push(0, 0, "x0_after_bp");
    push(2, 0, "x0_after_nb");
    push(5, 0, "x0_no_conflict");
    @(negedge clk);
    while (sbq.size() > 0) begin
      e = sbq.pop_front(); o = observe(e.sel); tests++;
      if (o !== e.exp) begin failed++; $display("FAIL %s: got %h expected %h", e.tag, o, e.exp); end
    end
  endtask

  task automatic test_dual();
    exp_t e;
    logic [63:0] o;
    @(posedge clk); #1;
    drive_wr(0, 1, 64'h1);
    drive_wr(1, 2, 64'h2);
    @(posedge clk); #1;
    idle();
    set_rs(0, 1);
    set_rs(1, 2);
    push(0, 64'h1, "dual_x1_bp");
    push(1, 64'h2, "dual_x2_bp");
    push(2, 64'h1, "dual_x1_nb");
    push(3, 64'h2, "dual_x2_nb");
    push(5, 0, "dual_no_conflict");
    @(negedge clk);
    while (sbq.size() > 0) begin
      e = sbq.pop_front(); o = observe(e.sel); tests++;
      if (o !== e.exp) begin failed++; $display("FAIL %s: got %h expected %h", e.tag, o, e.exp); end
    end
  endtask

  task automatic test_reset_mid();
    exp_t e;
    logic [63:0] o;
    int n;
    @(posedge clk); #1;
    drive_wr(1, 31, 64'hA5A5);
    set_rs(0, 31);
    push(0, 64'hA5A5, "x31_bypass");
    @(negedge clk);
    while (sbq.size() > 0) begin
      e = sbq.pop_front(); o = observe(e.sel); tests++;
      if (o !== e.exp) begin failed++; $display("FAIL %s: got %h expected %h", e.tag, o, e.exp); end
    end
    @(posedge clk); #1;
    idle();
    push(2, 64'hA5A5, "x31_stored_nb");
    @(negedge clk);
    while (sbq.size() > 0) begin
      e = sbq.pop_front(); o = observe(e.sel); tests++;
      if (o !== e.exp) begin failed++; $display("FAIL %s: got %h expected %h", e.tag, o, e.exp); end
    end
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    push(4, 0, "midreset_ready_drop");
    push(0, 0, "midreset_read_zero");
    while (sbq.size() > 0) begin
      e = sbq.pop_front(); o = observe(e.sel); tests++;
      if (o !== e.exp) begin failed++; $display("FAIL %s: got %h expected %h", e.tag, o, e.exp); end
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    n = 0;
    @(negedge clk);
    while (ready_bp !== 1'b1 && n < 40) begin
      @(posedge clk); n++;
      @(negedge clk);
    end
    tests++;
    if (n !== 31) begin failed++; $display("FAIL midreset_latency: got %0d cycles expected 31", n); end
    push(0, 0, "x31_cleared_bp");
    push(2, 0, "x31_cleared_nb");
    while (sbq.size() > 0) begin
      e = sbq.pop_front(); o = observe(e.sel); tests++;
      if (o !== e.exp) begin failed++; $display("FAIL %s: got %h expected %h", e.tag, o, e.exp); end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n    = 1'b0;
    wr_rd    = '0;
    wr_wdata = '0;
    wr_wen   = '0;
    rs       = '0;
    test_reset();
    test_bypass();
    test_conflict();
    test_zero();
    test_dual();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised successor to the single-write, two-read integer register file. Generalised in data width, register count, read-port count and write-port count.
- Sits between decode (read ports) and write-back (write ports) of the core pipeline.
- Adds three things the earlier block lacks: a post-reset clear sequencer with a ready flag, configurable write-to-read bypass, and deterministic same-cycle write-conflict priority.

Parameters:
- XLEN, 64, data width of each register.
- NREGS, 32, number of architectural registers; power of two, minimum 4.
- AW, $clog2(NREGS), register index width; derived, never overridden.
- NUM_RD, 2, number of read ports, 1..4.
- NUM_WR, 2, number of write ports, 1..2.
- BYPASS, 1, 1 = a same-cycle write is visible on the read ports; 0 = reads return stored array content only.

Ports:
- clk  in  1  clock, all state updates on posedge.
- rst_n  in  1  reset, asynchronous, active-low.
- write_back_i_rd  in  NUM_WR*AW  destination index per write port; port k occupies slice [k*AW +: AW].
- write_back_i_reg_wdata  in  NUM_WR*XLEN  write data per write port.
- write_back_i_reg_wen  in  NUM_WR  write enable per write port.
- decode_i_rs  in  NUM_RD*AW  source index per read port.
- regfile_o_reg_rdata  out  NUM_RD*XLEN  read data per read port (combinational).
- regfile_o_ready  out  1  high once the clear sequence has completed.
- regfile_o_wr_conflict  out  1  registered pulse: in the previous cycle two enabled write ports targeted the same non-zero index.

Behaviour:
- Only one clock and one reset; no other clock or reset inputs.
- Reset affects control state only: the FSM, the clear counter, regfile_o_ready and regfile_o_wr_conflict. The storage array has no reset.
- While rst_n=0: FSM=CLEAR, counter=1, regfile_o_ready=0, regfile_o_wr_conflict=0.
- FSM state CLEAR, entered on reset:
  - Each cycle writes 0 to entry[counter], then counter increments.
  - When counter == NREGS-1, that entry is written and the FSM moves to RUN.
  - Total duration is NREGS-1 cycles after reset release.
  - All write ports are ignored; every read port returns 0; regfile_o_ready=0.
- FSM state RUN:
  - regfile_o_ready=1, registered, asserted in the first RUN cycle.
  - The FSM stays in RUN until the next reset.
- Reset asserted in the middle of CLEAR (or RUN) restarts the sequence at counter=1. The counter never wraps past NREGS-1.
- Index 0:
  - Never written.
  - Always reads 0, in both states and with or without bypass.
  - Writes to index 0 are dropped and do not count toward a conflict.
- Writes (RUN only):
  - Port k commits on the posedge when wen[k]=1 and rd[k]!=0.
  - If both ports are enabled and target the same index, port NUM_WR-1 (the higher index) wins, and regfile_o_wr_conflict=1 in the following cycle.
  - Ports targeting different indices both commit.
- Reads:
  - Combinational, zero-cycle latency.
  - BYPASS=1: if any enabled write port targets rs this cycle, output that port's wdata, with the highest-numbered matching port winning. Otherwise output the array entry.
  - BYPASS=0: always output the array entry, so a write is visible on the cycle after the posedge.
- Width rules: no sign extension or truncation anywhere. All data paths are exactly XLEN bits and all indices exactly AW bits.

Decomposition:
- Shared package regfile_pkg holds:
  - default XLEN and NREGS;
  - the FSM state enum (CLEAR, RUN);
  - ZERO_REG = 0.
- One natural sub-module: regfile_rd_bypass. It is instantiated NUM_RD times and maps one rs plus the write-port vectors plus the array entry to rdata, applying the index-0 and priority rules.
- The clear FSM, write logic and array stay in regfile_mp.

Test Plan (all with XLEN=64, NREGS=32, NUM_RD=2, NUM_WR=2):
- Release reset → regfile_o_ready rises after exactly 31 cycles. Writing 0x55 to x5 during that window leaves x5 at 0 once ready.
- Ready; port0 writes x3=0xDEAD_BEEF; BYPASS=1 → rs0=3 reads 0xDEAD_BEEF in the same cycle. With BYPASS=0 → reads 0 in the same cycle and 0xDEAD_BEEF the next cycle.
- Ready; port0 x7=0x1111 and port1 x7=0x2222 in the same cycle → x7=0x2222; regfile_o_wr_conflict=1 for exactly one cycle.
- Ready; port0 x0=0xFFFF and port1 x0=0x1234 → rs0=0 reads 0 with bypass on and off; regfile_o_wr_conflict stays 0.
- Ready; write x31=0xA5A5, then pulse rst_n low for 1 cycle mid-operation → ready drops immediately, returns 31 cycles after release, and x31 then reads 0.
- Ready; port0 x1=0x1 and port1 x2=0x2 in the same cycle; rs0=1, rs1=2 next cycle → 0x1 and 0x2; no conflict.
